// File: rtl/imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe
//   Registered RV32/RV64 immediate generator for the decode stage. Each
//   instruction accepted on the input handshake is decoded into its extended
//   immediate, format code and illegal-opcode flag. The result leaves on the
//   output handshake one cycle later, together with its sideband tag. A
//   two-entry skid (output register + skid register) gives full throughput
//   and strict FIFO order under backpressure.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous reset, active-high
//   flush        in   1      synchronous flush, drops all buffered entries
//   in_valid     in   1      instruction valid
//   in_ready     out  1      buffer can accept this cycle (registered)
//   in_instr     in   32     full instruction word
//   in_tag       in   TAG_W  sideband tag
//   out_valid    out  1      output entry valid
//   out_ready    in   1      consumer accepts the output entry
//   out_imm      out  XLEN   extended immediate
//   out_fmt      out  3      0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
//   out_illegal  out  1      opcode not recognised
//   out_tag      out  TAG_W  tag of the output entry
//   illegal_cnt  out  CNT_W  saturating count of accepted illegal opcodes
// ----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 8,
    parameter bit ZICSR_EN = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [6:0]      w_opc;
    logic [31:0]     w_imm32;
    logic [2:0]      w_fmt;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;

    assign w_opc = in_instr[6:0];

    always_comb begin
        w_imm32   = 32'd0;
        w_fmt     = FMT_NONE;
        w_illegal = 1'b0;
        case (w_opc)
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_fmt   = FMT_I;
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0011011: begin
                // OP-IMM-32 only exists on RV64
                if (XLEN == 64) begin
                    w_fmt   = FMT_I;
                    w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                end else begin
                    w_illegal = 1'b1;
                end
            end
            7'b0100011: begin
                w_fmt   = FMT_S;
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                w_fmt   = FMT_B;
                w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_fmt   = FMT_U;
                w_imm32 = {in_instr[31:12], 12'd0};
            end
            7'b1101111: begin
                w_fmt   = FMT_J;
                w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
            end
            7'b1110011: begin
                // funct3[2] selects the immediate CSR forms; others carry no imm
                if (ZICSR_EN && in_instr[14]) begin
                    w_fmt   = FMT_Z;
                    w_imm32 = {27'd0, in_instr[19:15]};
                end
            end
            7'b0110011, 7'b0001111: begin
                w_fmt = FMT_NONE;
            end
            7'b0111011: begin
                // OP-32 only exists on RV64
                if (XLEN != 64) begin
                    w_illegal = 1'b1;
                end
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Every 32-bit form above is already sign-correct at bit 31 (zimm has a
    // zero there), so one sign extension to XLEN covers all formats.
    assign w_imm = XLEN'($signed(w_imm32));

    // ------------------------------------------------------------------
    // Output register + skid register
    // ------------------------------------------------------------------
    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_imm;
    logic [2:0]       r_out_fmt;
    logic             r_out_illegal;
    logic [TAG_W-1:0] r_out_tag;

    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic [2:0]       r_skid_fmt;
    logic             r_skid_illegal;
    logic [TAG_W-1:0] r_skid_tag;

    logic [CNT_W-1:0] r_illegal_cnt;

    logic w_accept;
    logic w_drain;

    assign in_ready = ~r_skid_valid;
    assign w_accept = in_valid & ~r_skid_valid;
    assign w_drain  = r_out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_imm      <= '0;
            r_out_fmt      <= FMT_NONE;
            r_out_illegal  <= 1'b0;
            r_out_tag      <= '0;
            r_skid_valid   <= 1'b0;
            r_skid_imm     <= '0;
            r_skid_fmt     <= FMT_NONE;
            r_skid_illegal <= 1'b0;
            r_skid_tag     <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            // in_ready is low here, so no accept can happen this cycle
            if (w_drain) begin
                r_out_imm     <= r_skid_imm;
                r_out_fmt     <= r_skid_fmt;
                r_out_illegal <= r_skid_illegal;
                r_out_tag     <= r_skid_tag;
                r_skid_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_out_valid || w_drain) begin
                r_out_valid   <= 1'b1;
                r_out_imm     <= w_imm;
                r_out_fmt     <= w_fmt;
                r_out_illegal <= w_illegal;
                r_out_tag     <= in_tag;
            end else begin
                r_skid_valid   <= 1'b1;
                r_skid_imm     <= w_imm;
                r_skid_fmt     <= w_fmt;
                r_skid_illegal <= w_illegal;
                r_skid_tag     <= in_tag;
            end
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal_cnt <= '0;
        end else if (!flush && w_accept && w_illegal && (r_illegal_cnt != CNT_MAX)) begin
            r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
        end
    end

    assign out_valid   = r_out_valid;
    assign out_imm     = r_out_imm;
    assign out_fmt     = r_out_fmt;
    assign out_illegal = r_out_illegal;
    assign out_tag     = r_out_tag;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Two instances share one stimulus stream: u_a is RV32 with CSR-immediate
//   decode, u_b is RV64 without it and with a 2-bit illegal counter. Each
//   vector row carries the expected result for both instances.
// ----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'd0;
    logic [7:0]  in_tag = 8'd0;
    logic        out_ready = 1'b1;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm;
    logic [2:0]  a_out_fmt;
    logic [7:0]  a_out_tag;
    logic [15:0] a_cnt;

    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm;
    logic [2:0]  b_out_fmt;
    logic [7:0]  b_out_tag;
    logic [1:0]  b_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .ZICSR_EN(1'b1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm(a_out_imm), .out_fmt(a_out_fmt),
        .out_illegal(a_out_illegal), .out_tag(a_out_tag),
        .illegal_cnt(a_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .ZICSR_EN(1'b0), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_imm(b_out_imm), .out_fmt(b_out_fmt),
        .out_illegal(b_out_illegal), .out_tag(b_out_tag),
        .illegal_cnt(b_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a_imm;
        logic [2:0]  a_fmt;
        logic        a_ill;
        logic [63:0] b_imm;
        logic [2:0]  b_fmt;
        logic        b_ill;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled at negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] instr, input logic [7:0] tag);
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
    endtask

    initial begin
        //                instr          a_imm          fmt  ill   b_imm                   fmt  ill
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0}; // addi -1
        vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0}; // beq -4
        vecs[2]  = '{32'h800002B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0}; // lui
        vecs[3]  = '{32'h300FD073, 32'h0000001F, 3'd6, 1'b0, 64'h0,                3'd0, 1'b0}; // csrrwi
        vecs[4]  = '{32'hFE20AC23, 32'hFFFFFFF8, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0}; // sw -8
        vecs[5]  = '{32'h0080006F, 32'h00000008, 3'd5, 1'b0, 64'h8,                3'd5, 1'b0}; // jal +8
        vecs[6]  = '{32'h0000007F, 32'h0,        3'd0, 1'b1, 64'h0,                3'd0, 1'b1}; // bad opc
        vecs[7]  = '{32'h0010109B, 32'h0,        3'd0, 1'b1, 64'h1,                3'd1, 1'b0}; // addiw-ish
        vecs[8]  = '{32'h002081B3, 32'h0,        3'd0, 1'b0, 64'h0,                3'd0, 1'b0}; // add
        vecs[9]  = '{32'h0000003B, 32'h0,        3'd0, 1'b1, 64'h0,                3'd0, 1'b0}; // addw
        vecs[10] = '{32'h41F0D093, 32'h0000041F, 3'd1, 1'b0, 64'h41F,              3'd1, 1'b0}; // srai 31
        vecs[11] = '{32'h30009073, 32'h0,        3'd0, 1'b0, 64'h0,                3'd0, 1'b0}; // csrrw
        vecs[12] = '{32'h00001097, 32'h00001000, 3'd4, 1'b0, 64'h1000,             3'd4, 1'b0}; // auipc
        vecs[13] = '{32'h0FF0000F, 32'h0,        3'd0, 1'b0, 64'h0,                3'd0, 1'b0}; // fence
        vecs[14] = '{32'h8000A083, 32'hFFFFF800, 3'd1, 1'b0, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0}; // lw -2048
        vecs[15] = '{32'h000080E7, 32'h0,        3'd1, 1'b0, 64'h0,                3'd1, 1'b0}; // jalr 0

        // ---------------- reset state ----------------
        #2;
        chk("rst_a_valid", {63'd0, a_out_valid}, 64'd0);
        chk("rst_a_ready", {63'd0, a_in_ready}, 64'd1);
        chk("rst_a_imm",   {32'd0, a_out_imm}, 64'd0);
        chk("rst_a_misc",  {44'd0, a_out_fmt, a_out_illegal, a_out_tag, a_cnt}, 64'd0);
        chk("rst_b_valid", {63'd0, b_out_valid}, 64'd0);
        chk("rst_b_imm",   b_out_imm, 64'd0);
        chk("rst_b_misc",  {50'd0, b_out_fmt, b_out_illegal, b_out_tag, b_cnt}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- back-to-back decode table ----------------
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].instr, 8'(i + 16));
            tick();
            chk($sformatf("v%0d_a_valid", i), {63'd0, a_out_valid}, 64'd1);
            chk($sformatf("v%0d_a_imm", i),   {32'd0, a_out_imm}, {32'd0, vecs[i].a_imm});
            chk($sformatf("v%0d_a_fmt_ill_tag", i), {52'd0, a_out_fmt, a_out_illegal, a_out_tag},
                {52'd0, vecs[i].a_fmt, vecs[i].a_ill, 8'(i + 16)});
            chk($sformatf("v%0d_b_imm", i),   b_out_imm, vecs[i].b_imm);
            chk($sformatf("v%0d_b_fmt_ill", i), {60'd0, b_out_fmt, b_out_illegal},
                {60'd0, vecs[i].b_fmt, vecs[i].b_ill});
        end
        in_valid = 1'b0;
        tick();
        chk("table_a_empty", {63'd0, a_out_valid}, 64'd0);
        chk("table_a_cnt",   {48'd0, a_cnt}, 64'd3);
        chk("table_b_cnt",   {62'd0, b_cnt}, 64'd1);

        // ---------------- backpressure: A, B, C ----------------
        out_ready = 1'b0;
        send(32'h00100093, 8'hA1);  // addi +1
        tick();
        send(32'h00200093, 8'hB2);  // addi +2
        tick();
        send(32'h00300093, 8'hC3);  // addi +3, must be held off
        chk("bp_ready_low", {63'd0, a_in_ready}, 64'd0);
        chk("bp_out_a",     {55'd0, a_out_valid, a_out_tag}, {55'd0, 1'b1, 8'hA1});
        tick();
        tick();
        chk("bp_hold_tag",  {55'd0, a_out_valid, a_out_tag}, {55'd0, 1'b1, 8'hA1});
        chk("bp_hold_imm",  {32'd0, a_out_imm}, 64'd1);
        chk("bp_hold_rdy",  {63'd0, a_in_ready}, 64'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_out_b",     {55'd0, a_out_valid, a_out_tag}, {55'd0, 1'b1, 8'hB2});
        chk("bp_out_b_imm", {32'd0, a_out_imm}, 64'd2);
        chk("bp_ready_up",  {63'd0, a_in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_out_c",     {55'd0, a_out_valid, a_out_tag}, {55'd0, 1'b1, 8'hC3});
        chk("bp_out_c_imm", {32'd0, a_out_imm}, 64'd3);
        tick();
        chk("bp_empty",     {63'd0, a_out_valid}, 64'd0);

        // ---------------- illegal counter, saturation ----------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(32'h0000007F, 8'(i));
            tick();
            chk($sformatf("cnt_ill_%0d", i), {62'd0, a_out_illegal, b_out_illegal}, 64'd3);
            if (i == 2) begin
                chk("cnt_a_3", {48'd0, a_cnt}, 64'd3);
                chk("cnt_b_3", {62'd0, b_cnt}, 64'd3);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("cnt_a_5",   {48'd0, a_cnt}, 64'd5);
        chk("cnt_b_sat", {62'd0, b_cnt}, 64'd3);

        // ---------------- flush with two entries buffered ----------------
        out_ready = 1'b0;
        send(32'h00100093, 8'h11);
        tick();
        send(32'h00200093, 8'h22);
        tick();
        in_valid = 1'b0;
        chk("fl_full", {62'd0, a_out_valid, a_in_ready}, {62'd0, 2'b10});
        flush = 1'b1;
        tick();
        chk("fl_empty", {62'd0, a_out_valid, a_in_ready}, {62'd0, 2'b01});
        // accept attempted during flush is dropped and not counted
        send(32'h0000007F, 8'h33);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_drop_valid", {63'd0, a_out_valid}, 64'd0);
        chk("fl_cnt_kept",   {48'd0, a_cnt}, 64'd5);
        out_ready = 1'b1;
        tick();
        chk("fl_still_empty", {62'd0, a_out_valid, b_out_valid}, 64'd0);

        // ---------------- async reset mid-stream ----------------
        send(32'hFFF00093, 8'h44);
        tick();
        chk("ar_valid_before", {63'd0, a_out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid_now", {62'd0, a_out_valid, b_out_valid}, 64'd0);
        chk("ar_cnt_now",   {46'd0, a_cnt, b_cnt}, 64'd0);
        chk("ar_regs_now",  {32'd0, a_out_imm}, 64'd0);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t limit 200000", $time);
        $fatal(1);
    end

endmodule
